// File: rtl/jerky_counter_gen.sv
// -----------------------------------------------------------------------------
// jerky_counter_gen
//
// Purpose:
//   WIDTH-bit one-hot "jerky" counter. It alternates between the base value 1
//   and a walking peak 2^p, with p in [1, WIDTH-1]. Walking up (dir=0) for
//   WIDTH=8 the sequence is 1,2,1,4,1,8,...,1,128,1,2,... (period 2*(WIDTH-1)).
//   The walk can be reversed, held, or restarted. It also reports where the
//   current value sits in the up-sequence, and strobes when the walk wraps.
//
// Ports:
//   clock   in   1        rising-edge clock
//   reset   in   1        synchronous active-high reset (highest priority)
//   enable  in   1        1 = advance one step on this edge, 0 = hold
//   dir     in   1        0 = peaks walk LSB->MSB, 1 = peaks walk MSB->LSB
//   clear   in   1        synchronous restart to the reset state
//   count   out  WIDTH    current value, always one-hot (1 or 2^p)
//   step    out  STEP_W   position of count in the up-sequence
//   wrap    out  1        one-cycle strobe with the post-wrap base value
//
// All outputs come straight from registers; there is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module jerky_counter_gen #(
  parameter  int WIDTH    = 8,
  localparam int STEP_RAW = $clog2(2 * (WIDTH - 1)),
  localparam int STEP_W   = (STEP_RAW < 1) ? 1 : STEP_RAW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              dir,
  input  logic              clear,
  output logic [WIDTH-1:0]  count,
  output logic [STEP_W-1:0] step,
  output logic              wrap
);

  // Peak pointer holds values 1 .. WIDTH-1.
  localparam int P_W = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
  localparam logic [P_W-1:0] P_MIN = P_W'(1);
  localparam logic [P_W-1:0] P_MAX = P_W'(WIDTH - 1);

  typedef enum logic {
    BASE = 1'b0,
    PEAK = 1'b1
  } phase_e;

  phase_e              phase_q, phase_d;
  logic [P_W-1:0]      p_q, p_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                wrap_q, wrap_d;
  logic [WIDTH-1:0]    count_q, count_d;

  // Up-sequence index of the base value that sits just below peak p: 2*(p-1).
  function automatic logic [STEP_W-1:0] base_index(input logic [P_W-1:0] p);
    logic [P_W:0] idx;
    idx = {p - P_MIN, 1'b0};
    return STEP_W'(idx);
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= BASE;
      p_q     <= P_MIN;
      step_q  <= '0;
      wrap_q  <= 1'b0;
      count_q <= WIDTH'(1);
    end else begin
      phase_q <= phase_d;
      p_q     <= p_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    phase_d = phase_q;
    p_d     = p_q;
    step_d  = step_q;
    wrap_d  = 1'b0;

    if (clear) begin
      phase_d = BASE;
      p_d     = P_MIN;
      step_d  = '0;
    end else if (enable) begin
      unique case (phase_q)
        BASE: begin
          // Rise to the peak at the current pointer.
          phase_d = PEAK;
          step_d  = base_index(p_q) | STEP_W'(1);
        end
        PEAK: begin
          // Fall back to 1 and move the pointer; dir only matters here.
          phase_d = BASE;
          if (!dir) begin
            if (p_q == P_MAX) begin
              p_d    = P_MIN;
              wrap_d = 1'b1;
            end else begin
              p_d = p_q + P_W'(1);
            end
            // Walking up, this 1 is the one just below the new peak.
            step_d = base_index(p_d);
          end else begin
            if (p_q == P_MIN) begin
              p_d    = P_MAX;
              wrap_d = 1'b1;
            end else begin
              p_d = p_q - P_W'(1);
            end
            // Walking down traverses the up-sequence backwards: this 1 is the
            // one just below the peak we are leaving, so the index drops by 1.
            step_d = base_index(p_q);
          end
        end
        default: begin
          phase_d = BASE;
          p_d     = P_MIN;
          step_d  = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // One-hot decode of the next value, registered with the rest of the state.
  // Bit 0 is the base value; bit gi (gi >= 1) is peak gi.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_onehot
      if (gi == 0) begin : g_base_bit
        assign count_d[gi] = (phase_d == BASE);
      end else begin : g_peak_bit
        assign count_d[gi] = (phase_d == PEAK) && (p_d == P_W'(gi));
      end
    end
  endgenerate

  assign count = count_q;
  assign step  = step_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_jerky_counter_gen.sv
module tb_jerky_counter_gen;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // WIDTH=8 instance
  logic       rst8 = 1'b0, en8 = 1'b0, dir8 = 1'b0, clr8 = 1'b0;
  logic [7:0] count8;
  logic [3:0] step8;
  logic       wrap8;

  // WIDTH=2 instance
  logic       rst2 = 1'b0, en2 = 1'b0, dir2 = 1'b0, clr2 = 1'b0;
  logic [1:0] count2;
  logic [0:0] step2;
  logic       wrap2;

  // WIDTH=16 instance
  logic        rst16 = 1'b0, en16 = 1'b0, dir16 = 1'b0, clr16 = 1'b0;
  logic [15:0] count16;
  logic [4:0]  step16;
  logic        wrap16;

  jerky_counter_gen #(.WIDTH(8)) u_w8 (
    .clock(clock), .reset(rst8), .enable(en8), .dir(dir8), .clear(clr8),
    .count(count8), .step(step8), .wrap(wrap8)
  );

  jerky_counter_gen #(.WIDTH(2)) u_w2 (
    .clock(clock), .reset(rst2), .enable(en2), .dir(dir2), .clear(clr2),
    .count(count2), .step(step2), .wrap(wrap2)
  );

  jerky_counter_gen #(.WIDTH(16)) u_w16 (
    .clock(clock), .reset(rst16), .enable(en16), .dir(dir16), .clear(clr16),
    .count(count16), .step(step16), .wrap(wrap16)
  );

  typedef struct {
    int    c;
    int    s;
    int    w;
    string nm;
  } exp_t;

  exp_t q8[$];
  exp_t q2[$];

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act == exp_v) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
  endtask

  // Drivers: apply inputs for one edge, push the expected post-edge outputs.
  task automatic drv8(input logic r, input logic c, input logic e, input logic d,
                      input int ec, input int es, input int ew, input string nm);
    @(negedge clock);
    rst8 = r; clr8 = c; en8 = e; dir8 = d;
    @(posedge clock);
    q8.push_back('{ec, es, ew, nm});
  endtask

  task automatic drv2(input logic r, input logic e, input logic d,
                      input int ec, input int es, input int ew, input string nm);
    @(negedge clock);
    rst2 = r; clr2 = 1'b0; en2 = e; dir2 = d;
    @(posedge clock);
    q2.push_back('{ec, es, ew, nm});
  endtask

  // Monitors: one line per transaction, compare away from the active edge.
  always @(negedge clock) begin
    if (q8.size() > 0) begin
      exp_t it;
      it = q8.pop_front();
      $display("w8  %-10s count=%0d step=%0d wrap=%0d (exp %0d/%0d/%0d)",
               it.nm, count8, step8, wrap8, it.c, it.s, it.w);
      chk({it.nm, ".count"}, int'(count8), it.c);
      chk({it.nm, ".step"},  int'(step8),  it.s);
      chk({it.nm, ".wrap"},  int'(wrap8),  it.w);
    end
  end

  always @(negedge clock) begin
    if (q2.size() > 0) begin
      exp_t it;
      it = q2.pop_front();
      $display("w2  %-10s count=%0d step=%0d wrap=%0d (exp %0d/%0d/%0d)",
               it.nm, count2, step2, wrap2, it.c, it.s, it.w);
      chk({it.nm, ".count"}, int'(count2), it.c);
      chk({it.nm, ".step"},  int'(step2),  it.s);
      chk({it.nm, ".wrap"},  int'(wrap2),  it.w);
    end
  end

  int t1_c[15] = '{2, 1, 4, 1, 8, 1, 16, 1, 32, 1, 64, 1, 128, 1, 2};
  int t1_s[15] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 0, 1};
  int t2_c[7]  = '{2, 1, 128, 1, 64, 1, 32};
  int t2_s[7]  = '{1, 0, 13, 12, 11, 10, 9};
  int t5_c[6]  = '{1, 4, 1, 2, 1, 128};
  int t5_s[6]  = '{4, 3, 2, 1, 0, 13};

  int inv_bad = 0;

  initial begin
    // ---- 1: up walk with wrap ----
    drv8(1, 0, 0, 0, 1, 0, 0, "t1_rst");
    for (int i = 0; i < 15; i++)
      drv8(0, 0, 1, 0, t1_c[i], t1_s[i], (i == 13) ? 1 : 0, $sformatf("t1_%0d", i));

    // ---- 2: down walk from reset ----
    drv8(1, 0, 0, 1, 1, 0, 0, "t2_rst");
    for (int i = 0; i < 7; i++)
      drv8(0, 0, 1, 1, t2_c[i], t2_s[i], (i == 1) ? 1 : 0, $sformatf("t2_%0d", i));

    // ---- 3: hold at 16 ----
    drv8(1, 0, 0, 0, 1, 0, 0, "t3_rst");
    for (int i = 0; i < 7; i++)
      drv8(0, 0, 1, 0, t1_c[i], t1_s[i], 0, $sformatf("t3_up%0d", i));
    for (int i = 0; i < 5; i++)
      drv8(0, 0, 0, 0, 16, 7, 0, $sformatf("t3_hold%0d", i));
    drv8(0, 0, 1, 0, 1, 8, 0, "t3_re1");
    drv8(0, 0, 1, 0, 32, 9, 0, "t3_re2");

    // ---- 4: clear and reset+clear mid-run ----
    drv8(0, 0, 1, 0, 1, 10, 0, "t4_a");
    drv8(0, 0, 1, 0, 64, 11, 0, "t4_b");
    drv8(0, 1, 1, 0, 1, 0, 0, "t4_clr");
    drv8(0, 0, 1, 0, 2, 1, 0, "t4_c");
    drv8(0, 0, 1, 0, 1, 2, 0, "t4_d");
    drv8(0, 0, 1, 0, 4, 3, 0, "t4_e");
    drv8(1, 1, 1, 0, 1, 0, 0, "t4_rstclr");
    drv8(0, 0, 1, 0, 2, 1, 0, "t4_f");

    // ---- 5: direction flip at p=3 ----
    drv8(1, 0, 0, 0, 1, 0, 0, "t5_rst");
    for (int i = 0; i < 5; i++)
      drv8(0, 0, 1, 0, t1_c[i], t1_s[i], 0, $sformatf("t5_up%0d", i));
    for (int i = 0; i < 6; i++)
      drv8(0, 0, 1, 1, t5_c[i], t5_s[i], (i == 4) ? 1 : 0, $sformatf("t5_dn%0d", i));

    // ---- 6: WIDTH=2, both directions ----
    drv2(1, 0, 0, 1, 0, 0, "w2_rst");
    for (int i = 0; i < 6; i++)
      drv2(0, 1, 0, (i % 2 == 0) ? 2 : 1, (i % 2 == 0) ? 1 : 0, (i % 2 == 0) ? 0 : 1,
           $sformatf("w2_up%0d", i));
    for (int i = 0; i < 4; i++)
      drv2(0, 1, 1, (i % 2 == 0) ? 2 : 1, (i % 2 == 0) ? 1 : 0, (i % 2 == 0) ? 0 : 1,
           $sformatf("w2_dn%0d", i));

    // ---- WIDTH=16 random enable/dir, invariants every cycle ----
    @(negedge clock);
    rst16 = 1'b1;
    @(negedge clock);
    rst16 = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clock);
      if (!$onehot(count16) || step16 >= 5'd30 ||
          ((count16 == 16'd1) != (step16[0] == 1'b0)) ||
          (wrap16 && count16 != 16'd1))
        inv_bad++;
      en16  = ($urandom_range(0, 3) != 0);
      dir16 = ($urandom_range(0, 7) == 0) ? ~dir16 : dir16;
      clr16 = ($urandom_range(0, 199) == 0);
      rst16 = ($urandom_range(0, 999) == 0);
    end
    $display("w16 random run: %0d invariant violations", inv_bad);
    chk("w16_invariants", inv_bad, 0);

    @(negedge clock);
    @(negedge clock);
    chk("q8_drained", q8.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
